colisao_municao: RTL and testbench
==================================

# colisao_municao

Hit detector and life manager for the player ship. It sits directly downstream of the enemy-ammunition block. Each cycle it compares the enemy bullet position with the player ship bounding box and converts overlaps into single hits with an invulnerability window. It tracks remaining lives, raises game-over, and draws a lives HUD overlay from the VGA counters for the pixel mixer.

## Interface
Parameters:
- NAVE_W, 40, player ship width in pixels
- NAVE_H, 20, player ship height in pixels
- MUN_W, 1, bullet width in pixels
- MUN_H, 20, bullet height in pixels
- Y_MAX, 540, bullet Y at or above this is inactive
- VIDAS_INI, 3, lives after reset/restart (1..3)
- INVULN_CYCLES, 25000000, invulnerability length in clk cycles (≥2)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  async active-high reset
- posX_Municao2  in  11  bullet X (left edge)
- posY_Municao2  in  11  bullet Y (top edge); 0 = no bullet
- posX_nave  in  11  player ship X (left edge)
- posY_nave  in  11  player ship Y (top edge)
- btn_reiniciar  in  1  restart request, level, active-high, synchronous
- h_counter  in  10  VGA horizontal counter
- v_counter  in  10  VGA vertical counter
- hit  out  1  one-cycle pulse per accepted hit
- vidas  out  2  remaining lives
- invulneravel  out  1  high during invulnerability window
- game_over  out  1  high while in GAME_OVER
- R, G, B  out  8 each  HUD pixel colour

## Operation
- Input stage: all position inputs are registered every cycle into internal copies (bx, by, sx, sy).
- Bullet valid: by != 0 and by < Y_MAX.
- Overlap: valid, bx < sx+NAVE_W, sx < bx+MUN_W, by < sy+NAVE_H, sy < by+MUN_H.
  - All sums use 12-bit unsigned arithmetic, so the comparison never wraps.
- FSM states: JOGANDO, INVULNERAVEL, GAME_OVER.
- JOGANDO, on overlap:
  - hit=1 for one cycle.
  - vidas decrements by 1.
  - If vidas was 1: vidas becomes 0, go to GAME_OVER.
  - Otherwise: go to INVULNERAVEL and clear the counter.
- INVULNERAVEL:
  - Overlaps are ignored.
  - The counter increments each cycle.
  - When the counter reaches INVULN_CYCLES-1, return to JOGANDO on the next edge.
  - invulneravel=1 throughout this state.
- GAME_OVER:
  - Overlaps are ignored; game_over=1.
  - btn_reiniciar=1 sets vidas=VIDAS_INI, clears the counter and goes to JOGANDO.
- btn_reiniciar is ignored outside GAME_OVER.
- vidas never underflows below 0.
- HUD outputs, registered:
  - If v_counter<=2 or h_counter<=96: black.
  - Else, for i in 0..vidas-1, pixels with h_counter in [110+16i, 119+16i] and v_counter in [10,19] are green (0,255,0).
  - In GAME_OVER, the block h_counter in [110,157], v_counter in [10,19] is red (255,0,0).
  - Everything else is black.

## Timing
- Reset values:
  - hit=0, vidas=VIDAS_INI, invulneravel=0, game_over=0.
  - R=G=B=0.
  - State JOGANDO; counter and input copies = 0.
- Hit latency: an overlap present on the inputs at edge k is captured at edge k.
  - At edge k+1: hit=1, vidas is updated, and the state changes.
  - hit falls at edge k+2.
- Persistent overlap yields exactly one hit, because the state is INVULNERAVEL from edge k+1 onward.
- Invulnerability lasts exactly INVULN_CYCLES cycles.
  - invulneravel rises at edge k+1 and falls at edge k+1+INVULN_CYCLES.
  - An overlap sampled on the edge that returns to JOGANDO is not counted; the first eligible sample is on the following edge.
- Restart: btn_reiniciar sampled high at edge m in GAME_OVER gives game_over=0 and vidas=VIDAS_INI at edge m.
- HUD colour reflects counters and vidas with 1-cycle latency.
- Reset asserted mid-invulnerability or in GAME_OVER returns everything to reset values immediately, without waiting for a clock edge.

## Test plan
- Ship (100,400), bullet (120,390) held -> one hit pulse 2 cycles later, vidas 3→2, invulneravel high for exactly INVULN_CYCLES (bench sets 16), no second hit while overlap persists.
- Bullet (139,400) vs ship (100,400) -> hit; bullet (140,400) -> no hit; bullet Y=0 or Y=540 anywhere -> no hit.
- Three separated overlaps -> vidas 3,2,1,0, game_over=1 after third hit; further overlaps -> no hit, vidas stays 0.
- In GAME_OVER assert btn_reiniciar one cycle -> vidas=3, game_over=0; btn_reiniciar during JOGANDO -> no change.
- Assert reset mid-invulnerability (counter=8) -> all outputs reset values at once, next overlap counted normally.
- vidas=2, scan h=110..160 at v=15 -> green at 110–119 and 126–135, black elsewhere; h=96 or v=2 -> black.

Source files
------------

// File: rtl/colisao_municao_if.sv
// Bus bundle between the player-ship hit detector and its surroundings:
// enemy bullet / ship positions, restart, VGA counters in; hit, lives, HUD out.
interface colisao_municao_if;
  logic [10:0] posX_Municao2;
  logic [10:0] posY_Municao2;
  logic [10:0] posX_nave;
  logic [10:0] posY_nave;
  logic        btn_reiniciar;
  logic [9:0]  h_counter;
  logic [9:0]  v_counter;
  logic        hit;
  logic [1:0]  vidas;
  logic        invulneravel;
  logic        game_over;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;

  modport master (
    output posX_Municao2, posY_Municao2, posX_nave, posY_nave,
    output btn_reiniciar, h_counter, v_counter,
    input  hit, vidas, invulneravel, game_over, R, G, B
  );

  modport slave (
    input  posX_Municao2, posY_Municao2, posX_nave, posY_nave,
    input  btn_reiniciar, h_counter, v_counter,
    output hit, vidas, invulneravel, game_over, R, G, B
  );
endinterface

// File: rtl/colisao_municao.sv
// Player-ship hit detector and life manager: turns bullet/ship overlaps into
// single hits with an invulnerability window, tracks lives and draws the lives HUD.
module colisao_municao #(
  parameter int unsigned NAVE_W        = 40,
  parameter int unsigned NAVE_H        = 20,
  parameter int unsigned MUN_W         = 1,
  parameter int unsigned MUN_H         = 20,
  parameter int unsigned Y_MAX         = 540,
  parameter int unsigned VIDAS_INI     = 3,
  parameter int unsigned INVULN_CYCLES = 25000000
) (
  input logic               clk,
  input logic               reset,
  colisao_municao_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(INVULN_CYCLES);

  typedef enum logic [1:0] {
    JOGANDO      = 2'd0,
    INVULNERAVEL = 2'd1,
    GAME_OVER    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [10:0]       bx_q, bx_d, by_q, by_d, sx_q, sx_d, sy_q, sy_d;
  logic [1:0]        vidas_q, vidas_d;
  logic              hit_q, hit_d;
  logic              invuln_q, invuln_d;
  logic              game_over_q, game_over_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;

  logic [11:0]       bx12, by12, sx12, sy12;
  logic              valid_c, overlap_c;
  logic [5:0]        off_c;
  logic              blank_c, in_row_c, in_span_c, green_c, red_c;

  // Input copies; 12-bit sums keep the box comparisons from wrapping
  always_comb begin
    bx_d = bus.posX_Municao2;
    by_d = bus.posY_Municao2;
    sx_d = bus.posX_nave;
    sy_d = bus.posY_nave;
    bx12 = {1'b0, bx_q};
    by12 = {1'b0, by_q};
    sx12 = {1'b0, sx_q};
    sy12 = {1'b0, sy_q};
    valid_c   = (by_q != 11'd0) && (by12 < 12'(Y_MAX));
    overlap_c = valid_c
             && (bx12 < sx12 + 12'(NAVE_W)) && (sx12 < bx12 + 12'(MUN_W))
             && (by12 < sy12 + 12'(NAVE_H)) && (sy12 < by12 + 12'(MUN_H));
  end

  // Next-state, lives and invulnerability counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vidas_d = vidas_q;
    hit_d   = 1'b0;
    case (state_q)
      JOGANDO: begin
        if (overlap_c) begin
          hit_d = 1'b1;
          if (vidas_q <= 2'd1) begin
            vidas_d = 2'd0;
            state_d = GAME_OVER;
          end else begin
            vidas_d = vidas_q - 2'd1;
            cnt_d   = '0;
            state_d = INVULNERAVEL;
          end
        end
      end
      INVULNERAVEL: begin
        if (cnt_q == CNT_W'(INVULN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = JOGANDO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAME_OVER: begin
        if (bus.btn_reiniciar) begin
          vidas_d = 2'(VIDAS_INI);
          cnt_d   = '0;
          state_d = JOGANDO;
        end
      end
      default: state_d = JOGANDO;
    endcase
    invuln_d    = (state_d == INVULNERAVEL);
    game_over_d = (state_d == GAME_OVER);
  end

  // HUD: 10-px life squares on a 16-px pitch from x=110, red bar when game over
  always_comb begin
    off_c     = 6'(bus.h_counter - 10'd110);
    blank_c   = (bus.v_counter <= 10'd2) || (bus.h_counter <= 10'd96);
    in_row_c  = (bus.v_counter >= 10'd10) && (bus.v_counter <= 10'd19);
    in_span_c = (bus.h_counter >= 10'd110) && (bus.h_counter <= 10'd157);
    green_c   = in_row_c && in_span_c && (off_c[3:0] <= 4'd9) && (off_c[5:4] < vidas_q);
    red_c     = in_row_c && in_span_c && (state_q == GAME_OVER);
    r_d = 8'd0;
    g_d = 8'd0;
    b_d = 8'd0;
    if (!blank_c) begin
      if (red_c) begin
        r_d = 8'hFF;
      end else if (green_c) begin
        g_d = 8'hFF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= JOGANDO;
      cnt_q       <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      vidas_q     <= 2'(VIDAS_INI);
      hit_q       <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      vidas_q     <= vidas_d;
      hit_q       <= hit_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign bus.hit          = hit_q;
  assign bus.vidas        = vidas_q;
  assign bus.invulneravel = invuln_q;
  assign bus.game_over    = game_over_q;
  assign bus.R            = r_q;
  assign bus.G            = g_q;
  assign bus.B            = b_q;

endmodule

// File: tb/tb_colisao_municao.sv
// Directed bench for colisao_municao: hit latency, invulnerability window,
// box edges, game over / restart, async reset and HUD pixels.
module tb_colisao_municao;
  localparam int unsigned N = 16;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  colisao_municao_if bus_if ();

  colisao_municao #(.INVULN_CYCLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bullet(input int x, input int y);
    bus_if.posX_Municao2 = 11'(x);
    bus_if.posY_Municao2 = 11'(y);
  endtask

  task automatic set_ship(input int x, input int y);
    bus_if.posX_nave = 11'(x);
    bus_if.posY_nave = 11'(y);
  endtask

  initial begin
    logic [23:0] exp_rgb;
    reset = 1'b1;
    set_bullet(0, 0);
    set_ship(0, 0);
    bus_if.btn_reiniciar = 1'b0;
    bus_if.h_counter = 10'd0;
    bus_if.v_counter = 10'd0;
    tick(2);
    chk("rst_hit", 32'(bus_if.hit), 32'd0);
    chk("rst_vidas", 32'(bus_if.vidas), 32'd3);
    chk("rst_inv", 32'(bus_if.invulneravel), 32'd0);
    chk("rst_go", 32'(bus_if.game_over), 32'd0);
    chk("rst_rgb", 32'({bus_if.R, bus_if.G, bus_if.B}), 32'd0);
    reset = 1'b0;

    // First hit with overlap held through the whole window
    set_ship(100, 400);
    set_bullet(120, 390);
    tick(1);
    chk("lat_capture_hit", 32'(bus_if.hit), 32'd0);
    tick(1);
    chk("hit1_hit", 32'(bus_if.hit), 32'd1);
    chk("hit1_vidas", 32'(bus_if.vidas), 32'd2);
    chk("hit1_inv", 32'(bus_if.invulneravel), 32'd1);
    chk("hit1_go", 32'(bus_if.game_over), 32'd0);
    for (int j = 1; j < N; j++) begin
      tick(1);
      chk("inv_hold_hit", 32'(bus_if.hit), 32'd0);
      chk("inv_hold_inv", 32'(bus_if.invulneravel), 32'd1);
    end
    set_bullet(120, 0);
    tick(1);
    chk("inv_end_inv", 32'(bus_if.invulneravel), 32'd0);
    chk("inv_end_hit", 32'(bus_if.hit), 32'd0);
    tick(1);
    chk("after_inv_hit", 32'(bus_if.hit), 32'd0);
    chk("after_inv_vidas", 32'(bus_if.vidas), 32'd2);

    // Box and validity edges
    set_bullet(140, 400);
    tick(2);
    chk("x140_miss", 32'(bus_if.hit), 32'd0);
    set_ship(100, 0);
    set_bullet(120, 0);
    tick(2);
    chk("y0_miss", 32'(bus_if.hit), 32'd0);
    set_ship(100, 530);
    set_bullet(120, 540);
    tick(2);
    chk("y540_miss", 32'(bus_if.hit), 32'd0);
    chk("edges_vidas", 32'(bus_if.vidas), 32'd2);
    set_ship(100, 400);
    set_bullet(139, 400);
    tick(2);
    chk("x139_hit", 32'(bus_if.hit), 32'd1);
    chk("hit2_vidas", 32'(bus_if.vidas), 32'd1);
    set_bullet(0, 0);
    tick(1);
    chk("hit2_fall", 32'(bus_if.hit), 32'd0);
    tick(N);
    chk("hit2_inv_end", 32'(bus_if.invulneravel), 32'd0);

    // Third hit -> game over, further overlaps ignored
    set_bullet(120, 390);
    tick(2);
    chk("hit3_hit", 32'(bus_if.hit), 32'd1);
    chk("hit3_vidas", 32'(bus_if.vidas), 32'd0);
    chk("hit3_go", 32'(bus_if.game_over), 32'd1);
    chk("hit3_inv", 32'(bus_if.invulneravel), 32'd0);
    tick(1);
    chk("go_fall", 32'(bus_if.hit), 32'd0);
    tick(4);
    chk("go_nohit", 32'(bus_if.hit), 32'd0);
    chk("go_vidas", 32'(bus_if.vidas), 32'd0);
    chk("go_hold", 32'(bus_if.game_over), 32'd1);
    bus_if.h_counter = 10'd120;
    bus_if.v_counter = 10'd15;
    tick(1);
    chk("hud_red", 32'({bus_if.R, bus_if.G, bus_if.B}), 32'h00FF0000);

    // Restart, then restart button while playing
    set_bullet(0, 0);
    bus_if.btn_reiniciar = 1'b1;
    tick(1);
    chk("restart_go", 32'(bus_if.game_over), 32'd0);
    chk("restart_vidas", 32'(bus_if.vidas), 32'd3);
    bus_if.btn_reiniciar = 1'b0;
    tick(2);
    chk("restart_nohit", 32'(bus_if.hit), 32'd0);
    bus_if.btn_reiniciar = 1'b1;
    tick(2);
    chk("btn_play_vidas", 32'(bus_if.vidas), 32'd3);
    chk("btn_play_go", 32'(bus_if.game_over), 32'd0);
    chk("btn_play_inv", 32'(bus_if.invulneravel), 32'd0);
    bus_if.btn_reiniciar = 1'b0;

    // Async reset in the middle of invulnerability
    set_bullet(120, 390);
    tick(2);
    chk("hit4_hit", 32'(bus_if.hit), 32'd1);
    chk("hit4_vidas", 32'(bus_if.vidas), 32'd2);
    set_bullet(0, 0);
    tick(8);
    chk("mid_inv", 32'(bus_if.invulneravel), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_vidas", 32'(bus_if.vidas), 32'd3);
    chk("async_inv", 32'(bus_if.invulneravel), 32'd0);
    chk("async_hit", 32'(bus_if.hit), 32'd0);
    chk("async_go", 32'(bus_if.game_over), 32'd0);
    tick(1);
    reset = 1'b0;
    set_bullet(120, 390);
    tick(2);
    chk("post_rst_hit", 32'(bus_if.hit), 32'd1);
    chk("post_rst_vidas", 32'(bus_if.vidas), 32'd2);
    chk("post_rst_inv", 32'(bus_if.invulneravel), 32'd1);
    set_bullet(0, 0);
    tick(N + 2);
    chk("post_rst_inv_end", 32'(bus_if.invulneravel), 32'd0);

    // HUD scan with two lives
    bus_if.v_counter = 10'd15;
    for (int h = 110; h <= 160; h++) begin
      bus_if.h_counter = 10'(h);
      tick(1);
      exp_rgb = ((h >= 110 && h <= 119) || (h >= 126 && h <= 135)) ? 24'h00FF00 : 24'h000000;
      chk("hud_scan", 32'({bus_if.R, bus_if.G, bus_if.B}), 32'(exp_rgb));
    end
    bus_if.h_counter = 10'd96;
    tick(1);
    chk("hud_h96", 32'({bus_if.R, bus_if.G, bus_if.B}), 32'd0);
    bus_if.h_counter = 10'd115;
    bus_if.v_counter = 10'd2;
    tick(1);
    chk("hud_v2", 32'({bus_if.R, bus_if.G, bus_if.B}), 32'd0);
    bus_if.v_counter = 10'd10;
    tick(1);
    chk("hud_v10", 32'({bus_if.R, bus_if.G, bus_if.B}), 32'h0000FF00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
